// File: rtl/p_if_queue.sv
// Instruction fetch unit with a QUEUE_DEPTH-entry prefetch queue between the memory controller
// fetch port and decode. Optional 32-bit perf counters are built when IF_PERF_EN is defined.
module p_if_queue #(
    parameter int unsigned       QUEUE_DEPTH = 4,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INST_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [1:0]        PORT_ID     = 2'b01
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              jump,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              mem_stall,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_len,
    output logic [1:0]        mem_port_id,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [INST_W-1:0] inst_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              busy_out
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_discard_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pc_mem_q   [QUEUE_DEPTH];
    logic [INST_W-1:0] inst_mem_q [QUEUE_DEPTH];

    logic adv;
    logic accept_jump;
    logic push;
    logic pop;
    logic room;
    logic issue;

    always_comb begin
        adv         = rdy_in && !mem_stall;
        accept_jump = adv && jump;
        push        = adv && !jump && (state_q == StWait) && mem_done;
        pop         = adv && !jump && out_valid && out_ready;
        // A push landing this cycle consumes a slot the new request would otherwise rely on.
        room        = (count_q + CNT_W'(push)) < CNT_W'(QUEUE_DEPTH);
        issue       = adv && !jump && (state_q == StIdle) && !mem_busy && room;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_re_d   = mem_re_q;
        mem_addr_d = mem_addr_q;
        if (adv) begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = StWait;
                    end
                end
                StWait: begin
                    if (mem_done) begin
                        mem_re_d = 1'b0;
                        state_d  = StIdle;
                        pc_d     = pc_q + ADDR_W'(4);
                    end else if (jump) begin
                        state_d = StDiscard;
                    end
                end
                StDiscard: begin
                    if (mem_done) begin
                        mem_re_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
                default: begin
                    mem_re_d = 1'b0;
                    state_d  = StIdle;
                end
            endcase
            if (accept_jump) begin
                pc_d = next_addr;
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (accept_jump) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= pc_q;
                inst_mem_q[wr_ptr_q] <= inst_in;
            end
        end
    end

    always_comb begin
        mem_re      = mem_re_q;
        mem_addr    = mem_addr_q;
        mem_len     = 3'd4;
        mem_port_id = PORT_ID;
        out_valid   = (count_q != '0);
        busy_out    = (count_q == '0);
        out_inst    = inst_mem_q[rd_ptr_q];
        out_pc      = pc_mem_q[rd_ptr_q];
    end

`ifdef IF_PERF_EN
    logic             drop;
    logic [CNT_W:0]   discard_inc;
    logic [32:0]      fetch_sum;
    logic [32:0]      discard_sum;
    logic [31:0]      perf_fetch_q;
    logic [31:0]      perf_discard_q;

    always_comb begin
        // A return is dropped when it lands in DISCARD or coincides with an accepted redirect.
        drop        = adv && mem_done && ((state_q == StDiscard) || ((state_q == StWait) && jump));
        discard_inc = (accept_jump ? {1'b0, count_q} : '0) + (CNT_W + 1)'(drop);
        fetch_sum   = {1'b0, perf_fetch_q} + 33'(push);
        discard_sum = {1'b0, perf_discard_q} + 33'(discard_inc);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_fetch_q   <= '0;
            perf_discard_q <= '0;
        end else if (adv) begin
            perf_fetch_q   <= fetch_sum[32] ? '1 : fetch_sum[31:0];
            perf_discard_q <= discard_sum[32] ? '1 : discard_sum[31:0];
        end
    end

    assign perf_fetch_cnt   = perf_fetch_q;
    assign perf_discard_cnt = perf_discard_q;
`endif

endmodule

// File: tb/tb_p_if_queue.sv
// Bench for p_if_queue: directed scenarios plus random traffic, every cycle compared against a
// queue-based reference model of the fetch stream.
module tb_p_if_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] next_addr = '0;
    logic        stall = 1'b0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic [31:0] inst_in = '0;
    logic        ready = 1'b0;

    logic        mem_re;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [1:0]  mem_port_id;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        busy_out;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    p_if_queue #(
        .QUEUE_DEPTH(DEPTH),
        .ADDR_W     (32),
        .INST_W     (32),
        .RESET_PC   (RPC),
        .PORT_ID    (2'b01)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .rdy_in     (rdy),
        .jump       (jump),
        .next_addr  (next_addr),
        .mem_stall  (stall),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_port_id(mem_port_id),
        .mem_busy   (busy),
        .mem_done   (done),
        .inst_in    (inst_in),
        .out_valid  (out_valid),
        .out_ready  (ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .busy_out   (busy_out)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_discard_cnt(perf_discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: fetched-but-undecoded PCs, next fetch PC, and the outstanding read
    // (0 none, 1 live, 2 to be dropped).
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    int          m_out;
    logic [31:0] m_req;
    logic [31:0] m_fetch;
    logic [31:0] m_disc;

    bit rnd_mode = 0, spur = 0, force_done = 0, jod = 0, rnd_lat = 0;
    int fix_lat = 0, cur_lat = 0, wcnt = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = RPC;
        m_out   = 0;
        m_req   = '0;
        m_fetch = '0;
        m_disc  = '0;
    endtask

    task automatic step();
        bit a, j, d, do_pop, do_issue;
        int was;
        @(negedge clk);
        if (rnd_mode) begin
            rdy   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 9) == 0);
            busy  = ($urandom_range(0, 4) == 0);
            ready = ($urandom_range(0, 9) < 6);
            if (!jump && $urandom_range(0, 19) == 0) begin
                jump = 1'b1;
                case ($urandom_range(0, 2))
                    0:       next_addr = 32'h0;
                    1:       next_addr = $urandom & ~32'h3;
                    default: next_addr = 32'hFFFF_FFF8;
                endcase
            end
        end
        // Controller: answers the open request after cur_lat extra cycles, repeats if unheard.
        if (mem_re) begin
            if (wcnt >= cur_lat) begin
                done    = 1'b1;
                inst_in = f(mem_addr);
                wcnt    = 0;
                cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : fix_lat;
            end else begin
                done    = 1'b0;
                inst_in = $urandom;
                wcnt++;
            end
        end else begin
            wcnt    = 0;
            cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : fix_lat;
            done    = force_done || (spur && $urandom_range(0, 7) == 0);
            inst_in = $urandom;
        end
        if (jod && done && mem_re) begin
            jump      = 1'b1;
            next_addr = 32'h0;
            jod       = 0;
        end
        #1;
        chk("out_valid", out_valid, (mq.size() != 0));
        chk("busy_out", busy_out, (mq.size() == 0));
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0]);
            chk("out_inst", out_inst, f(mq[0]));
        end
        chk("mem_re", mem_re, (m_out != 0));
        if (m_out == 1) chk("mem_addr", mem_addr, m_req);
`ifdef IF_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_discard", perf_discard_cnt, m_disc);
`endif
        a = rdy && !stall;
        j = jump;
        d = done;
        if (a) begin
            was      = m_out;
            do_pop   = !j && ready && (mq.size() != 0);
            do_issue = (was == 0) && !j && !busy && (mq.size() < DEPTH);
            if (j) begin
                m_disc += mq.size();
                mq.delete();
                m_pc = next_addr;
                if (was == 1 && !d) m_out = 2;
                else if (was != 0 && d) begin
                    m_out = 0;
                    m_disc++;
                end
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (was == 1 && d) begin
                    mq.push_back(m_req);
                    m_fetch++;
                    m_pc  = m_pc + 32'd4;
                    m_out = 0;
                end else if (was == 2 && d) begin
                    m_out = 0;
                    m_disc++;
                end
                if (do_issue) begin
                    m_out = 1;
                    m_req = m_pc;
                end
            end
        end
        @(posedge clk);
        #1;
        if (a && j) jump = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy_out", busy_out, 1);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("mem_len", 32'(mem_len), 4);
        chk("mem_port_id", 32'(mem_port_id), 1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        rdy = 1'b1; ready = 1'b1;

        // Streaming from RESET_PC with a one-cycle controller.
        for (int i = 0; i < 12; i++) step();

        // Redirect to 0 with decode blocked: queue fills and fetching stops.
        ready = 1'b0; jump = 1'b1; next_addr = 32'h0;
        for (int i = 0; i < 10 && jump; i++) step();
        chk("jump0_accepted", jump, 0);
        for (int i = 0; i < 20; i++) step();
        chk("full_no_fetch", mem_re, 0);
        chk("full_head_pc", out_pc, 32'h0);
        ready = 1'b1;
        for (int i = 0; i < 20 && !mem_re; i++) step();
        chk("resume_addr", mem_addr, 32'h10);
        for (int i = 0; i < 8; i++) step();

        // Redirect while waiting on the fetch of 0x8.
        fix_lat = 3; jump = 1'b1; next_addr = 32'h0;
        for (int i = 0; i < 60 && !(mem_re && mem_addr == 32'h8 && !jump); i++) step();
        chk("reach_wait_8", mem_addr, 32'h8);
        jump = 1'b1; next_addr = 32'h200;
        step();
        chk("flush_empty", out_valid, 0);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        chk("first_after_jump", out_pc, 32'h200);

        // Redirect to 0 landing on the same cycle as mem_done, decode ready.
        fix_lat = 0; jod = 1;
        for (int i = 0; i < 20 && (jod || jump); i++) step();
        chk("coinc_empty", out_valid, 0);
        for (int i = 0; i < 20 && !mem_re; i++) step();
        chk("coinc_next_addr", mem_addr, 32'h0);

        // Stall during WAIT with returns pulsing; redirect held under the stall.
        for (int i = 0; i < 20 && !mem_re; i++) step();
        begin
            logic [31:0] held;
            held = mem_addr;
            stall = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (i == 2) begin
                    jump = 1'b1; next_addr = 32'h300;
                end
                step();
                chk("stall_addr", mem_addr, held);
                chk("stall_re", mem_re, 1);
            end
            stall = 1'b0;
            step();
            for (int i = 0; i < 20 && !(mem_re && m_out == 1); i++) step();
            chk("redirect_after_stall", mem_addr, 32'h300);
        end

        // Random traffic.
        rnd_mode = 1; rnd_lat = 1; spur = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd_mode = 0; spur = 0; rnd_lat = 0; fix_lat = 1;
        rdy = 1'b1; stall = 1'b0; busy = 1'b0; ready = 1'b1; jump = 1'b0;

        // Asynchronous reset mid-fetch, then a stale return that must be ignored.
        for (int i = 0; i < 20 && !mem_re; i++) step();
        chk("pre_reset_re", mem_re, 1);
        rst = 1'b1;
        #1;
        chk("areset_mem_re", mem_re, 0);
        chk("areset_mem_addr", mem_addr, 0);
        chk("areset_out_valid", out_valid, 0);
        model_reset();
        wcnt = 0; done = 1'b0;
        #1 rst = 1'b0;
        force_done = 1;
        step();
        force_done = 0;
        for (int i = 0; i < 30; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
